// File: rtl/serial_subtractor_pkg.sv
// ----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the serial subtractor:
//   state_e    - FSM state encoding (IDLE, RUN, DONE)
//   cnt_width  - width of the slice counter, clog2(WIDTH/BPC), at least 1 bit
// ----------------------------------------------------------------------------
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A single-slice configuration (BPC == WIDTH) still needs a 1-bit counter
    // so that no zero-width vector is ever declared.
    function automatic int cnt_width(input int width, input int bpc);
        int n;
        n = width / bpc;
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_subtractor_sub_slice.sv
// ----------------------------------------------------------------------------
// sub_slice
// Purely combinational BPC-bit ripple-borrow subtractor slice: d = a - b - bin.
// Ports:
//   a    [BPC-1:0] in   minuend slice
//   b    [BPC-1:0] in   subtrahend slice
//   bin            in   borrow into the slice LSB
//   d    [BPC-1:0] out  difference slice
//   bout           out  borrow out of the slice MSB
// ----------------------------------------------------------------------------
module sub_slice #(
    parameter int BPC = 1
) (
    input  logic [BPC-1:0] a,
    input  logic [BPC-1:0] b,
    input  logic           bin,
    output logic [BPC-1:0] d,
    output logic           bout
);

    logic [BPC:0] chain;

    always_comb begin
        chain    = '0;
        d        = '0;
        chain[0] = bin;
        for (int i = 0; i < BPC; i++) begin
            d[i]       = a[i] ^ b[i] ^ chain[i];
            // Borrow when a<b for this bit, or a==b and a borrow is pending.
            chain[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
        end
    end

    assign bout = chain[BPC];

endmodule

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
// Multi-cycle subtractor computing D = A - B - Bin, BPC bits per clock,
// LSB slice first. A start in IDLE or DONE latches the operands; the result
// appears WIDTH/BPC edges later together with a one-cycle done pulse.
// Back-to-back operation: start held in DONE re-enters RUN directly.
//
// Parameters:
//   WIDTH  operand/result width, 2..64
//   BPC    bits per cycle, must divide WIDTH
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   start request (ignored while busy)
//   A, B   in   minuend / subtrahend, latched on an accepted start
//   Bin    in   borrow-in, latched on an accepted start
//   busy   out  high while in RUN
//   done   out  one-cycle pulse, result valid
//   D      out  registered difference, held until the next result
//   Br     out  registered borrow-out from the MSB
// Configuration macro:
//   SERIAL_SUBTRACTOR_SAT_EN  when defined, a final borrow clamps D to 0
//                             (Br still reports 1). Timing is unaffected.
// ----------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Br
);

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("serial_subtractor: WIDTH must be in 2..64");
    end
    if (BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_bpc
        $error("serial_subtractor: WIDTH must be an integer multiple of BPC");
    end

    localparam int            N    = WIDTH / BPC;
    localparam int            CW   = cnt_width(WIDTH, BPC);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [BPC-1:0]   sl_d;
    logic             sl_bout;
    logic [WIDTH-1:0] res_shift;

    // Operands are shifted right each RUN cycle, so the current slice is
    // always the low BPC bits.
    sub_slice #(.BPC(BPC)) u_slice (
        .a    (a_q[BPC-1:0]),
        .b    (b_q[BPC-1:0]),
        .bin  (borrow_q),
        .d    (sl_d),
        .bout (sl_bout)
    );

    // Result accumulates from the top: each new slice enters at the MSB end,
    // so after N cycles slice 0 has reached the LSB position.
    assign res_shift = WIDTH'({sl_d, res_q} >> BPC);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        res_d    = res_q;
        diff_d   = diff_q;
        bout_d   = bout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    cnt_d    = '0;
                    a_d      = A;
                    b_d      = B;
                    borrow_d = Bin;
                    res_d    = '0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d      = a_q >> BPC;
                b_d      = b_q >> BPC;
                borrow_d = sl_bout;
                res_d    = res_shift;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    bout_d  = sl_bout;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
                    diff_d  = sl_bout ? '0 : res_shift;
`else
                    diff_d  = res_shift;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            res_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = diff_q;
    assign Br   = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

`ifdef SERIAL_SUBTRACTOR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // WIDTH=8, BPC=1
    logic       start8, bin8, busy8, done8, br8;
    logic [7:0] a8, b8, d8;
    // WIDTH=8, BPC=4 (shares operands with the BPC=1 instance)
    logic       start84, busy84, done84, br84;
    logic [7:0] d84;
    // WIDTH=4, BPC=1,2,4
    logic       start4, bin4;
    logic [3:0] a4, b4;
    logic [2:0] busy4, done4, br4;
    logic [3:0] d4 [3];

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(8), .BPC(1)) u_w8b1 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Bin(bin8),
        .busy(busy8), .done(done8), .D(d8), .Br(br8)
    );

    serial_subtractor #(.WIDTH(8), .BPC(4)) u_w8b4 (
        .clk(clk), .rst_n(rst_n), .start(start84), .A(a8), .B(b8), .Bin(bin8),
        .busy(busy84), .done(done84), .D(d84), .Br(br84)
    );

    for (genvar k = 0; k < 3; k++) begin : g_w4
        serial_subtractor #(.WIDTH(4), .BPC(1 << k)) u_w4 (
            .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .Bin(bin4),
            .busy(busy4[k]), .done(done4[k]), .D(d4[k]), .Br(br4[k])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until done8 is seen or the budget expires; returns steps taken.
    task automatic wait8(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (done8 !== 1'b1 && cyc < 40);
    endtask

    initial begin
        int  cyc;
        bit  seen;
        int  diff;
        logic [3:0] ed;

        rst_n = 1'b0; start8 = 1'b0; start84 = 1'b0; start4 = 1'b0;
        a8 = '0; b8 = '0; bin8 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;

        // Reset state
        #2;
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        chk("rst_D",    d8,    8'h00);
        chk("rst_Br",   br8,   1'b0);
        step(); step();
        rst_n = 1'b1;
        step();

        // 5 - 3 - 0: busy for 8 cycles, then one done cycle
        a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t1_busy_done_run", {busy8, done8}, 2'b10);
            step();
        end
        chk("t1_busy_done_end", {busy8, done8}, 2'b01);
        chk("t1_D",  d8,  8'h02);
        chk("t1_Br", br8, 1'b0);
        step();
        chk("t1_idle", {busy8, done8}, 2'b00);
        chk("t1_D_hold", d8, 8'h02);

        // 3 - 5 - 1: wrap or saturate
        a8 = 8'h03; b8 = 8'h05; bin8 = 1'b1; start8 = 1'b1;
        step();
        start8 = 1'b0;
        wait8(cyc);
        chk("t2_latency", cyc, 8);
        chk("t2_D",  d8,  SAT ? 8'h00 : 8'hFD);
        chk("t2_Br", br8, 1'b1);

        // BPC=4: 0 - 0 - 1, done two edges after acceptance
        a8 = 8'h00; b8 = 8'h00; bin8 = 1'b1; start84 = 1'b1;
        step();
        start84 = 1'b0;
        chk("t3_busy", busy84, 1'b1);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (done84 !== 1'b1 && cyc < 20);
        chk("t3_latency", cyc, 2);
        chk("t3_D",  d84,  SAT ? 8'h00 : 8'hFF);
        chk("t3_Br", br84, 1'b1);

        // Back-to-back with start held; operand changes during RUN ignored
        a8 = 8'h40; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        step();
        chk("t4_busy0", busy8, 1'b1);
        a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1;
        wait8(cyc);
        chk("t4_lat0", cyc, 8);
        chk("t4_D0",  d8,  8'h3F);
        chk("t4_Br0", br8, 1'b0);
        a8 = 8'h10; b8 = 8'h20; bin8 = 1'b0;
        step();
        chk("t4_b2b_busy_done", {busy8, done8}, 2'b10);
        a8 = 8'hEE; b8 = 8'h01; bin8 = 1'b1;
        wait8(cyc);
        chk("t4_lat1", cyc, 8);
        chk("t4_D1",  d8,  SAT ? 8'h00 : 8'hF0);
        chk("t4_Br1", br8, 1'b1);
        a8 = 8'h80; b8 = 8'h7F; bin8 = 1'b1;
        step();
        start8 = 1'b0;
        chk("t4_busy2", busy8, 1'b1);
        wait8(cyc);
        chk("t4_lat2", cyc, 8);
        chk("t4_D2",  d8,  8'h00);
        chk("t4_Br2", br8, 1'b0);
        step();
        chk("t4_idle", {busy8, done8}, 2'b00);

        // Reset mid-RUN
        a8 = 8'h90; b8 = 8'h10; bin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        wait8(cyc);
        chk("t5_pre_D", d8, 8'h80);
        a8 = 8'h55; b8 = 8'h11; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step();
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy8, 1'b0);
        chk("t5_rst_done", done8, 1'b0);
        chk("t5_rst_D",    d8,    8'h00);
        chk("t5_rst_Br",   br8,   1'b0);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done8 !== 1'b0 || busy8 !== 1'b0) seen = 1'b1;
        end
        chk("t5_no_done_after_rst", seen, 1'b0);
        a8 = 8'hFF; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        wait8(cyc);
        chk("t5_lat", cyc, 8);
        chk("t5_D",  d8,  8'hFE);
        chk("t5_Br", br8, 1'b0);

        // Exhaustive WIDTH=4 against A-B-Bin for BPC 1, 2, 4
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    a4 = a[3:0]; b4 = b[3:0]; bin4 = c[0]; start4 = 1'b1;
                    step();
                    start4 = 1'b0;
                    chk("x_busy", busy4, 3'b111);
                    step(); step(); step(); step();
                    diff = a - b - c;
                    ed   = diff[3:0];
                    if (SAT && diff < 0) ed = 4'h0;
                    chk("x_done_bpc1", done4[0], 1'b1);
                    for (int k = 0; k < 3; k++) begin
                        chk("x_D",  d4[k],  ed);
                        chk("x_Br", br4[k], (diff < 0) ? 1'b1 : 1'b0);
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand/difference width in bits; legal values are 2..64.
REQ-002 Parameter BPC, default 1, bits processed per cycle; WIDTH SHALL be an integer multiple of BPC, with elaboration error otherwise.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to begin a subtraction; sampled on rising clk.
REQ-006 A  input  WIDTH  minuend; sampled only when start is accepted.
REQ-007 B  input  WIDTH  subtrahend; sampled only when start is accepted.
REQ-008 Bin  input  1  borrow-in to the LSB; sampled only when start is accepted.
REQ-009 busy  output  1  high while an operation is in progress (state RUN).
REQ-010 done  output  1  one-cycle pulse: result valid.
REQ-011 D  output  WIDTH  difference A - B - Bin.
REQ-012 Br  output  1  borrow-out from the MSB.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL be accepted: A, B and Bin are latched, the slice counter clears to 0, and the FSM goes to RUN.
REQ-015 start while in RUN SHALL be ignored and SHALL NOT disturb the operands, counter or partial result.
REQ-016 Each RUN cycle SHALL subtract one BPC-bit slice, LSB slice first, chaining the borrow from the previous slice (Bin for slice 0).
REQ-017 After N = WIDTH/BPC RUN cycles the FSM SHALL enter DONE; done=1 for exactly that one cycle, so done rises N edges after the accepting edge.
REQ-018 D and Br SHALL be registered and update together on the edge entering DONE; they SHALL hold until the next result completes.
REQ-019 DONE with start=0 SHALL go to IDLE; DONE with start=1 SHALL go directly to RUN (back-to-back operation, no idle cycle).
REQ-020 Arithmetic SHALL be unsigned modulo 2^WIDTH; Br=1 if and only if A < B + Bin as unbounded integers.
REQ-021 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, D=0, Br=0, with counter and operand registers cleared.
REQ-023 Reset asserted mid-RUN SHALL abandon the operation with no done pulse; the first start after rst_n deasserts SHALL behave as from power-up.

Configuration
REQ-024 Macro SERIAL_SUBTRACTOR_SAT_EN: when defined, a final borrow of 1 SHALL clamp D to 0, and Br SHALL still report 1.
REQ-025 Without SERIAL_SUBTRACTOR_SAT_EN, D SHALL be the wrapped modulo-2^WIDTH difference.
REQ-026 The macro SHALL NOT change latency, handshake or port list.

Structure
REQ-027 Package serial_subtractor_pkg SHALL hold the FSM state enum typedef and the counter-width function (clog2 of WIDTH/BPC).
REQ-028 Sub-module sub_slice SHALL implement one purely combinational BPC-bit borrow-chain slice (inputs a, b, bin; outputs d, bout), instantiated once.

Verification
REQ-029 WIDTH=8, BPC=1: A=0x05, B=0x03, Bin=0, start for 1 cycle -> busy high for 8 cycles, then done for 1 cycle with D=0x02, Br=0.
REQ-030 WIDTH=8, BPC=1: A=0x03, B=0x05, Bin=1 -> D=0xFD, Br=1; with SERIAL_SUBTRACTOR_SAT_EN -> D=0x00, Br=1.
REQ-031 WIDTH=8, BPC=4: A=0x00, B=0x00, Bin=1 -> done 2 edges after acceptance, D=0xFF, Br=1.
REQ-032 Hold start=1 continuously with new operands each done cycle -> consecutive results every N+1 cycles; start pulses during RUN do not change the current result.
REQ-033 Assert rst_n=0 at RUN cycle 3 -> outputs go to 0 immediately and no done occurs; after release, A=0xFF, B=0x01, Bin=0 -> D=0xFE, Br=0.
REQ-034 Exhaustive run, WIDTH=4, BPC in {1, 2, 4}: all A, B, Bin combinations match the reference model A-B-Bin for both D and Br.
